// File: rtl/fifo_word_serializer.sv
// Drains SIZE-bit words from a FIFO read port and emits them as SIZE/OUT_W narrower beats.
// Each word's last slice can overlap the pop of the next word, so back-to-back words have no gap.
module fifo_word_serializer #(
    parameter int unsigned SIZE      = 32,
    parameter int unsigned OUT_W     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [SIZE-1:0]  data_i,
    output logic             ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             busy_o
);

    localparam int unsigned RATIO = SIZE / OUT_W;
    localparam int unsigned CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [SIZE-1:0]   word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  slice_idx;
    logic [OUT_W-1:0]  slices [RATIO];
    logic              is_shift, is_last;

    always_comb begin
        for (int i = 0; i < int'(RATIO); i++) begin
            slices[i] = word_q[i*OUT_W +: OUT_W];
        end
    end

    always_comb begin
        is_shift  = (state_q == StShift);
        is_last   = is_shift && (cnt_q == CNT_LAST);
        slice_idx = MSB_FIRST ? (CNT_LAST - cnt_q) : cnt_q;
        valid_o   = is_shift;
        busy_o    = is_shift;
        last_o    = is_last;
        data_o    = is_shift ? slices[slice_idx] : '0;
        // Combinational from ready_i so the next word pops in the same cycle as the last beat.
        ready_o   = !is_shift || (is_last && ready_i);
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    word_d  = data_i;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (ready_i) begin
                    if (!is_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (valid_i) begin
                        word_d = data_i;
                        cnt_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Downstream drain stage for the `Fifo` block: pops SIZE-bit words from the FIFO read port with a valid/ready handshake and emits each word as SIZE/OUT_W narrower beats on a second valid/ready interface. It is used wherever a narrow consumer, such as a byte-wide link or UART TX, sits behind the FIFO. It sustains one output beat per cycle, with no bubble between consecutive words when the FIFO keeps `valid` high.

## Interface
- SIZE, 32, width of the input word; must equal the FIFO's SIZE.
- OUT_W, 8, width of one output beat. SIZE must be an integer multiple of OUT_W, with SIZE/OUT_W >= 2.
- MSB_FIRST, 1, beat order. 1 means the most-significant slice goes first; 0 means the least-significant slice goes first.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  FIFO has a word available; connects to the FIFO's valid_o.
- data_i  input  SIZE  FIFO head word; connects to the FIFO's data_o.
- ready_o  output  1  pop request; connects to the FIFO's ready_i.
- data_o  output  OUT_W  current output beat.
- valid_o  output  1  data_o holds a valid beat.
- ready_i  input  1  downstream accepts the beat.
- last_o  output  1  current beat is the final slice of its word.
- busy_o  output  1  a word is held and not yet fully emitted.

## Operation
- **Transfers.**
  - An input word is accepted on a rising edge where valid_i && ready_o.
  - An output beat transfers on a rising edge where valid_o && ready_i.
- **Registered state.**
  - word_q: SIZE bits, the held word.
  - cnt_q: beat index, $clog2(SIZE/OUT_W) bits, counting 0..RATIO-1, where RATIO = SIZE/OUT_W.
  - state_q: one of two states, IDLE or SHIFT.
- **IDLE.**
  - ready_o = 1, valid_o = 0.
  - On acceptance: word_q <= data_i, cnt_q <= 0, move to SHIFT.
- **SHIFT.**
  - valid_o = 1.
  - data_o is slice k of word_q, where k = RATIO-1-cnt_q if MSB_FIRST, else k = cnt_q. Slice k is word_q[k*OUT_W +: OUT_W].
  - last_o = (cnt_q == RATIO-1).
  - On a beat transfer with cnt_q < RATIO-1: cnt_q increments by 1.
  - On a beat transfer with cnt_q == RATIO-1 and valid_i = 1: load the next word, cnt_q <= 0, stay in SHIFT.
  - On a beat transfer with cnt_q == RATIO-1 and valid_i = 0: return to IDLE.
- **ready_o.** ready_o = (state_q == IDLE) || (state_q == SHIFT && last_o && ready_i). This is combinational from ready_i; the path is permitted and documented.
- **busy_o.** busy_o = (state_q == SHIFT).
- **Outputs outside SHIFT.** When valid_o = 0, data_o and last_o are driven to 0.
- **Backpressure.** While valid_o && !ready_i, data_o, last_o and cnt_q hold stable and no input word is accepted.
- **No truncation.** The block never drops or reorders a word. A word popped from the FIFO is always emitted completely unless rst_i asserts.

## Timing
- **Reset values.** While rst_i = 1, asynchronously and immediately: state_q = IDLE, cnt_q = 0, word_q = 0.
  - Outputs during reset: valid_o = 0, last_o = 0, busy_o = 0, data_o = 0, ready_o = 1.
- **Reset mid-word.** Asserting rst_i mid-word discards the remaining beats. valid_o drops in the same cycle, with no wait for a clock edge.
- **Latency.** The first beat of a word is valid in the cycle after acceptance, giving 1 cycle of latency.
- **Throughput.**
  - With ready_i held at 1, one word takes exactly RATIO cycles.
  - With the FIFO continuously valid, back-to-back words produce valid_o high with no gaps.
- **Empty FIFO.** With valid_i = 0 in IDLE, nothing changes and ready_o stays 1, mirroring the FIFO's popping semantics.
- **Simultaneous last beat and FIFO empty.** The block returns to IDLE. A word arriving in the next cycle is accepted in that cycle.
- **ready_i deasserted on the last beat.** ready_o = 0 and the FIFO head is not popped.

## Test plan
- **Basic MSB-first.** SIZE=32, OUT_W=8, MSB_FIRST=1; push 32'habcdefaa into the FIFO; ready_i = 1.
  - Expect data_o = ab, cd, ef, aa on 4 consecutive cycles.
  - Expect last_o = 1 only on aa.
  - Expect ready_o pulsed once.
- **Back-to-back words.** FIFO holds 32'hdeaddead followed by 32'haaaaaaaa; ready_i = 1.
  - Expect 8 consecutive valid beats: de, ad, de, ad, aa, aa, aa, aa.
  - Expect last_o on beats 4 and 8, and no valid_o gap.
- **Backpressure.** Same word 32'habcdefaa; drop ready_i for 3 cycles while data_o = cd.
  - Expect cd held stable for 3 cycles and cnt_q unchanged.
  - Expect ef to follow once ready_i returns to 1, with the total sequence unchanged.
- **LSB-first.** MSB_FIRST=0; word 32'habcdefaa.
  - Expect aa, ef, cd, ab, with last_o on ab.
- **Reset mid-word.** Assert rst_i after beat cd of 32'hdddddddd... use 32'habcdefaa: after beat cd.
  - Expect valid_o = 0, busy_o = 0 and ready_o = 1 immediately.
  - After release, the next FIFO word emits from its first slice.
- **Empty and refill.** FIFO empty for 5 cycles, then one word is written.
  - During the empty cycles, expect valid_o = 0 and ready_o = 1.
  - Expect the first beat of the new word one cycle after the FIFO asserts valid.
